// File: rtl/spi_pkt_readout_pkg.sv
// Shared frame constants and FSM encoding for the SPI packet readout block.
// Build option: define SPI_PARITY_EN to append an even-parity bit to every frame.
package spi_pkt_readout_pkg;

  localparam int STATUS_W = 8;

`ifdef SPI_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int frame_w(input int data_w);
    return STATUS_W + data_w + PAR_W;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin, with single-clk edge pulses.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_pkt_readout.sv
// Captures packets from the shift buffer and serves them over an SPI mode-0 slave.
// Build option: SPI_PARITY_EN adds a trailing even-parity bit to the frame.
module spi_pkt_readout
  import spi_pkt_readout_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_rec,
  input  logic [DATA_W-1:0] spi_data,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              pkt_avail,
  output logic              ovf,
  output logic              busy
);

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  logic cs_lvl_unused, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               pkt_avail_q, pkt_avail_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               miso_q, miso_d;
  logic               mosi_first_q, mosi_first_d;

  logic [STATUS_W-1:0] status_c;
  logic [FRAME_W-1:0]  frame_c;

  always_comb begin
    status_c = {pkt_avail_q, ovf_q, (STATUS_W-2)'(pkt_cnt_q)};
`ifdef SPI_PARITY_EN
    frame_c  = {status_c, hold_q, ^{status_c, hold_q}};
`else
    frame_c  = {status_c, hold_q};
`endif
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    pkt_cnt_d    = pkt_cnt_q;
    pkt_avail_d  = pkt_avail_q;
    ovf_d        = ovf_q;
    busy_d       = busy_q;
    miso_d       = miso_q;
    mosi_first_d = mosi_first_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        miso_d = 1'b0;
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end else begin
          shift_d      = frame_c;
          miso_d       = frame_c[FRAME_W-1];
          bit_cnt_d    = '0;
          mosi_first_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == '0) mosi_first_d = mosi_s;
          // Last bit sampled by the host: finish without waiting for its fall.
          if (bit_cnt_q == BIT_W'(FRAME_W - 1)) state_d = ST_DONE;
        end else if (sclk_fall) begin
          shift_d = shift_q << 1;
          miso_d  = shift_q[FRAME_W-2];
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        miso_d      = 1'b0;
        pkt_avail_d = 1'b0;
        if (mosi_first_q) ovf_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A capture in the DONE cycle replaces the packet that was just read out.
    if (pkt_rec) begin
      if (!pkt_avail_q || state_q == ST_DONE) begin
        hold_d      = spi_data;
        pkt_avail_d = 1'b1;
        pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      pkt_cnt_q    <= '0;
      pkt_avail_q  <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      miso_q       <= 1'b0;
      mosi_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      pkt_cnt_q    <= pkt_cnt_d;
      pkt_avail_q  <= pkt_avail_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      miso_q       <= miso_d;
      mosi_first_q <= mosi_first_d;
    end
  end

  // Gate with the raw pin so miso is low the moment the host deselects.
  assign miso      = miso_q & ~cs;
  assign pkt_avail = pkt_avail_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_pkt_readout.sv
// Self-checking bench for spi_pkt_readout: table of capture/read vectors plus corner sequences.
module tb_spi_pkt_readout;

`ifdef SPI_PARITY_EN
  localparam int FRAME_W = 73;
`else
  localparam int FRAME_W = 72;
`endif
  localparam int HALF_HI = 4;
  localparam int HALF_LO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pkt_rec = 1'b0;
  logic [63:0] spi_data = '0;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso, pkt_avail, ovf, busy;

  spi_pkt_readout #(.DATA_W(64), .CNT_W(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .pkt_rec(pkt_rec), .spi_data(spi_data),
    .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso), .pkt_avail(pkt_avail), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_hold;
  logic        m_avail, m_ovf;
  logic [5:0]  m_cnt;
  logic [FRAME_W-1:0] sb_q[$];

  typedef struct {
    logic [63:0] data;
    logic        dup;
    logic        mosi_first;
    logic [7:0]  exp_status;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_W-1:0] exp_frame();
    logic [7:0] st;
    st = {m_avail, m_ovf, m_cnt};
`ifdef SPI_PARITY_EN
    return {st, m_hold, ^{st, m_hold}};
`else
    return {st, m_hold};
`endif
  endfunction

  task automatic model_cap(input logic [63:0] d);
    if (!m_avail) begin
      m_hold  = d;
      m_avail = 1'b1;
      m_cnt   = m_cnt + 6'd1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; pkt_rec = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    m_hold = '0; m_avail = 1'b0; m_ovf = 1'b0; m_cnt = '0;
    sb_q.delete();
  endtask

  task automatic capture(input logic [63:0] d);
    spi_data = d;
    pkt_rec  = 1'b1;
    tick(1);
    pkt_rec  = 1'b0;
    tick(1);
    model_cap(d);
  endtask

  // Drives cs low and clocks nbits; miso is sampled just before each sclk rise.
  task automatic spi_frame(input logic mosi_first, input int nbits, input bit rec_in_done,
                           input logic [63:0] rec_data, output logic [FRAME_W-1:0] got);
    got = '0;
    cs  = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      got  = {got[FRAME_W-2:0], miso};
      mosi = (i == 0) ? mosi_first : 1'b0;
      sclk = 1'b1;
      if (rec_in_done && i == FRAME_W - 1) begin
        tick(3);
        spi_data = rec_data;
        pkt_rec  = 1'b1;
        tick(1);
        pkt_rec  = 1'b0;
      end else begin
        tick(HALF_HI);
      end
      sclk = 1'b0;
      tick(HALF_LO);
    end
    mosi = 1'b0;
  endtask

  task automatic full_read(input string name, input logic mosi_first, input logic [7:0] exp_status,
                           input int extra);
    logic [FRAME_W-1:0] got, exp;
    sb_q.push_back(exp_frame());
    spi_frame(mosi_first, FRAME_W, 1'b0, '0, got);
    for (int e = 0; e < extra; e++) begin
      sclk = 1'b1;
      tick(HALF_HI);
      check($sformatf("%s extra_hi%0d miso", name, e), miso, 1'b0);
      sclk = 1'b0;
      tick(HALF_LO);
      check($sformatf("%s extra_lo%0d miso", name, e), miso, 1'b0);
    end
    cs = 1'b1;
    tick(6);
    exp = sb_q.pop_front();
    m_avail = 1'b0;
    if (mosi_first) m_ovf = 1'b0;
    check($sformatf("%s frame", name), got, exp);
    check($sformatf("%s status", name), got[FRAME_W-1 -: 8], exp_status);
    check($sformatf("%s pkt_avail", name), pkt_avail, m_avail);
    check($sformatf("%s ovf", name), ovf, m_ovf);
    check($sformatf("%s busy", name), busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] got, exp;

    vecs[0] = '{64'hF800_0000_0000_01FF, 1'b0, 1'b0, 8'h81, 1'b0};
    vecs[1] = '{64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 1'b1, 8'hC2, 1'b0};
    vecs[2] = '{64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 8'hC3, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 8'hC4, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 8'h85, 1'b0};

    do_reset();
    check("reset miso", miso, 1'b0);
    check("reset pkt_avail", pkt_avail, 1'b0);
    check("reset ovf", ovf, 1'b0);
    check("reset busy", busy, 1'b0);

    for (int v = 0; v < 5; v++) begin
      capture(vecs[v].data);
      if (vecs[v].dup) capture(~vecs[v].data);
      check($sformatf("vec%0d cap pkt_avail", v), pkt_avail, m_avail);
      check($sformatf("vec%0d cap ovf", v), ovf, m_ovf);
      full_read($sformatf("vec%0d", v), vecs[v].mosi_first, vecs[v].exp_status, (v == 0) ? 3 : 0);
      check($sformatf("vec%0d ovf after", v), ovf, vecs[v].exp_ovf);
    end

    // Two captures without a read: second dropped, ovf cleared by a mosi-1 read.
    do_reset();
    capture(64'h1111_2222_3333_4444);
    capture(64'h5555_6666_7777_8888);
    check("t2 ovf set", ovf, 1'b1);
    check("t2 pkt_avail", pkt_avail, 1'b1);
    full_read("t2", 1'b1, 8'hC1, 0);

    // Abort after 20 bits leaves the packet pending; re-read gives the same frame.
    do_reset();
    capture(64'hDEAD_BEEF_CAFE_F00D);
    exp = exp_frame();
    spi_frame(1'b0, 20, 1'b0, '0, got);
    check("t3 busy mid", busy, 1'b1);
    cs = 1'b1;
    tick(6);
    check("t3 partial bits", got, exp >> (FRAME_W - 20));
    check("t3 busy abort", busy, 1'b0);
    check("t3 pkt_avail kept", pkt_avail, 1'b1);
    check("t3 model frame", exp_frame(), exp);
    full_read("t3 reread", 1'b0, 8'h81, 0);

    // Capture in the DONE cycle wins over the read-clear.
    do_reset();
    capture(64'h0F0F_0F0F_0F0F_0F0F);
    sb_q.push_back(exp_frame());
    spi_frame(1'b0, FRAME_W, 1'b1, 64'h9876_5432_10FE_DCBA, got);
    cs = 1'b1;
    tick(6);
    exp = sb_q.pop_front();
    check("t4 frame", got, exp);
    m_avail = 1'b0;
    model_cap(64'h9876_5432_10FE_DCBA);
    check("t4 pkt_avail", pkt_avail, 1'b1);
    check("t4 ovf", ovf, 1'b0);
    full_read("t4 new", 1'b0, 8'h82, 0);

    // Counter wrap: the 64th capture reports count 0.
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      capture({32'(i), ~32'(i)});
      full_read($sformatf("t5 cap%0d", i), 1'b0, {2'b10, 6'(i)}, 0);
    end

`ifdef SPI_PARITY_EN
    do_reset();
    capture(64'h1);
    sb_q.push_back(exp_frame());
    spi_frame(1'b0, FRAME_W, 1'b0, '0, got);
    cs = 1'b1;
    tick(6);
    exp = sb_q.pop_front();
    m_avail = 1'b0;
    check("t6 parity frame", got, exp);
    check("t6 parity bit", got[0], 1'b1);
    check("t6 parity status", got[FRAME_W-1 -: 8], 8'h81);
`endif

    // Reset asserted mid-frame clears every output on the next edge.
    do_reset();
    capture(64'hFFFF_FFFF_FFFF_FFFF);
    capture(64'h0);
    exp = exp_frame();
    spi_frame(1'b0, 10, 1'b0, '0, got);
    check("t6 pre-reset miso", miso, exp[FRAME_W-1-10]);
    check("t6 pre-reset busy", busy, 1'b1);
    rst = 1'b0;
    tick(1);
    check("t6 rst miso", miso, 1'b0);
    check("t6 rst pkt_avail", pkt_avail, 1'b0);
    check("t6 rst ovf", ovf, 1'b0);
    check("t6 rst busy", busy, 1'b0);
    cs = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
